// File: rtl/jelly3_img_demosaic_ctl.sv
// AXI4-Lite control block for a multi-channel Bayer demosaic: holds per-channel phase/flip
// parameters and commits them to the datapath on frame starts, either armed or automatically.
module jelly3_img_demosaic_ctl #(
   parameter int unsigned CHANNELS         = 4,
   parameter int unsigned AXI4L_ADDR_BITS  = 12,
   parameter int unsigned AXI4L_DATA_BITS  = 32,
   parameter logic [31:0] CORE_ID          = 32'h527a_2111,
   parameter logic [31:0] CORE_VERSION     = 32'h0002_0000,
   parameter logic [2:0]  INIT_CTL_CONTROL = 3'b001,
   parameter logic [1:0]  INIT_PARAM_PHASE = 2'b00,
   parameter logic [1:0]  INIT_PARAM_FLIP  = 2'b00
) (
   input  logic                           s_axi4l_aclk,
   input  logic                           s_axi4l_aresetn,
   input  logic [AXI4L_ADDR_BITS-1:0]     s_axi4l_awaddr,
   input  logic                           s_axi4l_awvalid,
   output logic                           s_axi4l_awready,
   input  logic [AXI4L_DATA_BITS-1:0]     s_axi4l_wdata,
   input  logic [AXI4L_DATA_BITS/8-1:0]   s_axi4l_wstrb,
   input  logic                           s_axi4l_wvalid,
   output logic                           s_axi4l_wready,
   output logic [1:0]                     s_axi4l_bresp,
   output logic                           s_axi4l_bvalid,
   input  logic                           s_axi4l_bready,
   input  logic [AXI4L_ADDR_BITS-1:0]     s_axi4l_araddr,
   input  logic                           s_axi4l_arvalid,
   output logic                           s_axi4l_arready,
   output logic [AXI4L_DATA_BITS-1:0]     s_axi4l_rdata,
   output logic [1:0]                     s_axi4l_rresp,
   output logic                           s_axi4l_rvalid,
   input  logic                           s_axi4l_rready,
   input  logic                           in_update_req,
   input  logic [CHANNELS-1:0]            in_frame_start,
   output logic [CHANNELS-1:0]            out_enable,
   output logic [2*CHANNELS-1:0]          out_phase,
   output logic                           out_update_done
);

   localparam int unsigned STRB_BITS  = AXI4L_DATA_BITS / 8;
   localparam int unsigned ADDR_LSB   = $clog2(STRB_BITS);
   localparam int unsigned WADDR_BITS = AXI4L_ADDR_BITS - ADDR_LSB;
   localparam int unsigned GRP_BITS   = WADDR_BITS - 4;

   typedef logic [WADDR_BITS-1:0] waddr_t;
   typedef logic [GRP_BITS-1:0]   grp_t;

   // register state
   logic                         ctl_enable;
   logic                         ctl_auto;
   logic [CHANNELS-1:0][1:0]     param_phase;
   logic [CHANNELS-1:0][1:0]     param_flip;
   logic [CHANNELS-1:0]          arm;
   logic [CHANNELS-1:0]          req;
   logic                         arm_any_prev;
   logic [7:0]                   ctl_index;
   logic [CHANNELS-1:0][1:0]     cur_phase;

   // address decode
   waddr_t      wr_addr;
   waddr_t      rd_addr;
   grp_t        wr_grp;
   grp_t        rd_grp;
   logic [3:0]  wr_sel;
   logic [3:0]  rd_sel;
   logic        wr_en;
   logic        rd_en;
   logic        wr_byte0;
   logic        ctl_wr;

   assign wr_addr = s_axi4l_awaddr[AXI4L_ADDR_BITS-1:ADDR_LSB];
   assign rd_addr = s_axi4l_araddr[AXI4L_ADDR_BITS-1:ADDR_LSB];
   assign wr_grp  = wr_addr[WADDR_BITS-1:4];
   assign rd_grp  = rd_addr[WADDR_BITS-1:4];
   assign wr_sel  = wr_addr[3:0];
   assign rd_sel  = rd_addr[3:0];

   // AXI4-Lite handshakes: address and data are accepted together only
   assign s_axi4l_awready = (~s_axi4l_bvalid | s_axi4l_bready) & s_axi4l_wvalid;
   assign s_axi4l_wready  = (~s_axi4l_bvalid | s_axi4l_bready) & s_axi4l_awvalid;
   assign s_axi4l_arready = ~s_axi4l_rvalid | s_axi4l_rready;
   assign s_axi4l_bresp   = 2'b00;
   assign s_axi4l_rresp   = 2'b00;

   assign wr_en    = s_axi4l_awvalid & s_axi4l_awready;
   assign rd_en    = s_axi4l_arvalid & s_axi4l_arready;
   assign wr_byte0 = wr_en & s_axi4l_wstrb[0];
   assign ctl_wr   = wr_byte0 & (wr_addr == waddr_t'(4));

   // commit / arm / request next state
   logic [CHANNELS-1:0] commit;
   logic [CHANNELS-1:0] arm_next;
   logic [CHANNELS-1:0] req_next;

   always_comb begin
      commit   = in_frame_start & ({CHANNELS{ctl_auto}} | (arm & req));
      arm_next = arm & ~commit;
      if (ctl_wr && s_axi4l_wdata[1]) begin
         arm_next = '1;
      end
      req_next = req & ~commit;
      if (in_update_req) begin
         req_next = '1;
      end
   end

   // read mux
   logic [31:0] rd_word;

   always_comb begin
      rd_word = '0;
      case (rd_addr)
         waddr_t'('h00): rd_word = CORE_ID;
         waddr_t'('h01): rd_word = CORE_VERSION;
         waddr_t'('h03): rd_word = CHANNELS;
         waddr_t'('h04): rd_word = {29'd0, ctl_auto, |arm, ctl_enable};
         waddr_t'('h05): rd_word = 32'(out_enable);
         waddr_t'('h07): rd_word = {24'd0, ctl_index};
         default: begin
            for (int n = 0; n < CHANNELS; n++) begin
               if (rd_sel == 4'(n)) begin
                  if (rd_grp == grp_t'(2)) rd_word = {30'd0, param_phase[n]};
                  if (rd_grp == grp_t'(3)) rd_word = {30'd0, param_flip[n]};
                  if (rd_grp == grp_t'(4)) rd_word = {30'd0, cur_phase[n]};
               end
            end
         end
      endcase
   end

   // AXI response channels
   always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
      if (!s_axi4l_aresetn) begin
         s_axi4l_bvalid <= 1'b0;
         s_axi4l_rvalid <= 1'b0;
         s_axi4l_rdata  <= '0;
      end else begin
         if (wr_en) begin
            s_axi4l_bvalid <= 1'b1;
         end else if (s_axi4l_bready) begin
            s_axi4l_bvalid <= 1'b0;
         end
         if (rd_en) begin
            s_axi4l_rvalid <= 1'b1;
            s_axi4l_rdata  <= AXI4L_DATA_BITS'(rd_word);
         end else if (s_axi4l_rready) begin
            s_axi4l_rvalid <= 1'b0;
         end
      end
   end

   // registers and commit; commit reads pre-write register values
   always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
      if (!s_axi4l_aresetn) begin
         ctl_enable      <= INIT_CTL_CONTROL[0];
         ctl_auto        <= INIT_CTL_CONTROL[2];
         param_phase     <= {CHANNELS{INIT_PARAM_PHASE}};
         param_flip      <= {CHANNELS{INIT_PARAM_FLIP}};
         arm             <= '0;
         req             <= '0;
         arm_any_prev    <= 1'b0;
         ctl_index       <= 8'd0;
         out_update_done <= 1'b0;
         out_enable      <= '0;
         cur_phase       <= {CHANNELS{INIT_PARAM_PHASE ^ INIT_PARAM_FLIP}};
      end else begin
         if (ctl_wr) begin
            ctl_enable <= s_axi4l_wdata[0];
            ctl_auto   <= s_axi4l_wdata[2];
         end
         for (int n = 0; n < CHANNELS; n++) begin
            if (wr_byte0 && wr_sel == 4'(n)) begin
               if (wr_grp == grp_t'(2)) param_phase[n] <= s_axi4l_wdata[1:0];
               if (wr_grp == grp_t'(3)) param_flip[n]  <= s_axi4l_wdata[1:0];
            end
            if (commit[n]) begin
               out_enable[n] <= ctl_enable;
               cur_phase[n]  <= param_phase[n] ^ param_flip[n];
            end
         end
         arm          <= arm_next;
         req          <= req_next;
         arm_any_prev <= |arm;
         // completion is seen one cycle after the last arm bit drops
         if (arm_any_prev && !(|arm)) begin
            ctl_index       <= ctl_index + 8'd1;
            out_update_done <= 1'b1;
         end else begin
            out_update_done <= 1'b0;
         end
      end
   end

   assign out_phase = cur_phase;

endmodule

// File: tb/tb_jelly3_img_demosaic_ctl.sv
// Directed bench for jelly3_img_demosaic_ctl: register map table plus armed/auto commit,
// coincident request and mid-transaction reset sequences.
module tb_jelly3_img_demosaic_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [11:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        update_req;
   logic [3:0]  frame_start;
   logic [3:0]  enable;
   logic [7:0]  phase;
   logic        update_done;

   always #5 clk = ~clk;

   jelly3_img_demosaic_ctl dut (
      .s_axi4l_aclk    (clk),
      .s_axi4l_aresetn (rst_n),
      .s_axi4l_awaddr  (awaddr),
      .s_axi4l_awvalid (awvalid),
      .s_axi4l_awready (awready),
      .s_axi4l_wdata   (wdata),
      .s_axi4l_wstrb   (wstrb),
      .s_axi4l_wvalid  (wvalid),
      .s_axi4l_wready  (wready),
      .s_axi4l_bresp   (bresp),
      .s_axi4l_bvalid  (bvalid),
      .s_axi4l_bready  (bready),
      .s_axi4l_araddr  (araddr),
      .s_axi4l_arvalid (arvalid),
      .s_axi4l_arready (arready),
      .s_axi4l_rdata   (rdata),
      .s_axi4l_rresp   (rresp),
      .s_axi4l_rvalid  (rvalid),
      .s_axi4l_rready  (rready),
      .in_update_req   (update_req),
      .in_frame_start  (frame_start),
      .out_enable      (enable),
      .out_phase       (phase),
      .out_update_done (update_done)
   );

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   always @(posedge clk) begin
      if (update_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [9:0] wa, input logic [31:0] d, input logic [3:0] s);
      logic ok;
      @(negedge clk);
      awaddr = {wa, 2'b00};
      wdata = d;
      wstrb = s;
      awvalid = 1'b1;
      wvalid = 1'b1;
      bready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (awready && wready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      wvalid = 1'b0;
      check("aw_handshake", {31'd0, ok}, 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bvalid) begin
            ok = 1'b1;
            break;
         end
      end
      check("bvalid_seen", {30'd0, bresp, ok}, 32'd1);
   endtask

   task automatic axi_read(input logic [9:0] wa, output logic [31:0] d);
      logic ok;
      @(negedge clk);
      araddr = {wa, 2'b00};
      arvalid = 1'b1;
      rready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (arready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      @(negedge clk);
      if (!ok || !rvalid) begin
         total++;
         bad++;
         $display("FAIL read_timeout: rvalid=%b arready_seen=%b expected 1", rvalid, ok);
      end
      d = rdata;
   endtask

   task automatic read_check(input string name, input logic [9:0] wa, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(wa, d);
      check(name, d, exp);
   endtask

   task automatic pulse(input logic [3:0] fs, input logic ur);
      @(negedge clk);
      frame_start = fs;
      update_req = ur;
      @(posedge clk);
      #1;
      frame_start = '0;
      update_req = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [9:0]  wa;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int base;
      vecs[0]  = '{1'b0, 10'h000, 32'h0,        4'h0, 32'h527a2111, "core_id"};
      vecs[1]  = '{1'b0, 10'h001, 32'h0,        4'h0, 32'h00020000, "core_version"};
      vecs[2]  = '{1'b0, 10'h003, 32'h0,        4'h0, 32'h00000004, "config"};
      vecs[3]  = '{1'b0, 10'h004, 32'h0,        4'h0, 32'h00000001, "ctl_init"};
      vecs[4]  = '{1'b0, 10'h005, 32'h0,        4'h0, 32'h00000000, "status_init"};
      vecs[5]  = '{1'b0, 10'h007, 32'h0,        4'h0, 32'h00000000, "index_init"};
      vecs[6]  = '{1'b0, 10'h055, 32'h0,        4'h0, 32'h00000000, "unmapped_55"};
      vecs[7]  = '{1'b1, 10'h021, 32'hffffffff, 4'hf, 32'h0,        "wr_phase1"};
      vecs[8]  = '{1'b0, 10'h021, 32'h0,        4'h0, 32'h00000003, "phase1_rb"};
      vecs[9]  = '{1'b1, 10'h021, 32'h0,        4'hf, 32'h0,        "clr_phase1"};
      vecs[10] = '{1'b0, 10'h021, 32'h0,        4'h0, 32'h00000000, "phase1_clr_rb"};
      vecs[11] = '{1'b1, 10'h024, 32'h3,        4'hf, 32'h0,        "wr_phase4"};
      vecs[12] = '{1'b0, 10'h024, 32'h0,        4'h0, 32'h00000000, "phase4_ignored"};
      vecs[13] = '{1'b1, 10'h031, 32'h00000202, 4'h2, 32'h0,        "wr_flip1_b1"};
      vecs[14] = '{1'b0, 10'h031, 32'h0,        4'h0, 32'h00000000, "flip1_strb_ignored"};
      vecs[15] = '{1'b0, 10'h040, 32'h0,        4'h0, 32'h00000000, "cur_phase0_init"};

      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      update_req = 1'b0; frame_start = '0;
      repeat (3) @(negedge clk);
      check("rst_enable", 32'(enable), 32'h0);
      check("rst_phase", 32'(phase), 32'h0);
      check("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 32'h0);
      check("rst_done", 32'(update_done), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         logic [31:0] d;
         if (vecs[i].wr) begin
            axi_write(vecs[i].wa, vecs[i].data, vecs[i].strb);
         end else begin
            axi_read(vecs[i].wa, d);
            check(vecs[i].name, d, vecs[i].exp);
         end
      end

      // armed update: channel 2 first, then the rest
      axi_write(10'h022, 32'h1, 4'hf);
      axi_write(10'h032, 32'h3, 4'hf);
      axi_write(10'h004, 32'h3, 4'hf);
      read_check("ctl_armed", 10'h004, 32'h3);
      pulse(4'b0000, 1'b1);
      pulse(4'b0100, 1'b0);
      @(negedge clk);
      check("ch2_phase", 32'(phase[5:4]), 32'h2);
      check("ch2_enable", 32'(enable), 32'h4);
      read_check("ctl_still_armed", 10'h004, 32'h3);
      read_check("cur_phase2", 10'h042, 32'h2);
      check("no_done_yet", done_cnt, 0);
      pulse(4'b1011, 1'b0);
      repeat (4) @(negedge clk);
      check("done_once", done_cnt, 1);
      check("all_enable", 32'(enable), 32'hf);
      check("phase_after_update", 32'(phase), 32'h20);
      read_check("ctl_disarmed", 10'h004, 32'h1);
      read_check("index_1", 10'h007, 32'h1);
      read_check("status_all", 10'h005, 32'hf);

      // auto mode: commits every frame without touching the index
      axi_write(10'h004, 32'h5, 4'hf);
      axi_write(10'h020, 32'h3, 4'hf);
      pulse(4'b0001, 1'b0);
      pulse(4'b0001, 1'b0);
      repeat (3) @(negedge clk);
      check("auto_phase0", 32'(phase[1:0]), 32'h3);
      check("auto_phase_all", 32'(phase), 32'h23);
      check("auto_no_done", done_cnt, 1);
      read_check("auto_index", 10'h007, 32'h1);

      // request coincident with frame start is not used for that frame
      base = done_cnt;
      axi_write(10'h004, 32'h1, 4'hf);
      axi_write(10'h021, 32'h1, 4'hf);
      axi_write(10'h023, 32'h2, 4'hf);
      axi_write(10'h004, 32'h3, 4'hf);
      pulse(4'b1000, 1'b0);
      @(negedge clk);
      check("armed_no_req", 32'(phase[7:6]), 32'h0);
      pulse(4'b0010, 1'b1);
      @(negedge clk);
      check("coincident_req", 32'(phase[3:2]), 32'h0);
      pulse(4'b0010, 1'b0);
      @(negedge clk);
      check("next_frame_commit", 32'(phase[3:2]), 32'h1);
      pulse(4'b1000, 1'b0);
      read_check("ctl_partial", 10'h004, 32'h3);
      pulse(4'b0101, 1'b0);
      repeat (4) @(negedge clk);
      check("second_update_phase", 32'(phase), 32'ha7);
      check("second_done", done_cnt - base, 1);
      read_check("index_2", 10'h007, 32'h2);
      read_check("ctl_final", 10'h004, 32'h1);

      // reset while a write response is stalled
      @(negedge clk);
      awaddr = 12'h010; wdata = 32'h1; wstrb = 4'hf;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bvalid_stalled", 32'(bvalid), 32'h1);
      check("awready_blocked", {30'd0, awready, wready}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_bvalid", 32'(bvalid), 32'h0);
      check("rst_mid_enable", 32'(enable), 32'h0);
      check("rst_mid_phase", 32'(phase), 32'h0);
      check("rst_mid_r", {29'd0, update_done, rvalid, |rdata}, 32'h0);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("no_stale_bresp", 32'(bvalid), 32'h0);
      read_check("rst_index", 10'h007, 32'h0);
      read_check("rst_param", 10'h022, 32'h0);
      read_check("rst_ctl", 10'h004, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jelly3_img_demosaic_ctl.md
JELLY3_IMG_DEMOSAIC_CTL -- requirements
Module: jelly3_img_demosaic_ctl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CHANNELS, 4, number of independent demosaic channels (1..16).
- AXI4L_ADDR_BITS, 12, AXI4-Lite byte address width.
- AXI4L_DATA_BITS, 32, AXI4-Lite data width (32 or 64).
- CORE_ID, 32'h527a_2111, read-only identifier.
- CORE_VERSION, 32'h0002_0000, read-only version.
- INIT_CTL_CONTROL, 3'b001, reset value of CTL_CONTROL.
- INIT_PARAM_PHASE, 2'b00, reset value of every PARAM_PHASE.
- INIT_PARAM_FLIP, 2'b00, reset value of every PARAM_FLIP.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- s_axi4l_aclk, in, 1, the single clock for all logic.
- s_axi4l_aresetn, in, 1, reset, asynchronous, active-low.
- s_axi4l_aw*/w*/b*/ar*/r*, AXI4-Lite slave: addr AXI4L_ADDR_BITS, data AXI4L_DATA_BITS, strb AXI4L_DATA_BITS/8, resp 2.
- in_update_req, in, 1, one-cycle request permitting an armed update.
- in_frame_start, in, CHANNELS, per-channel frame-start strobe (valid&row_first&col_first&cke).
- out_enable, out, CHANNELS, committed per-channel enable.
- out_phase, out, 2*CHANNELS, committed effective Bayer phase, channel n at [2n+1:2n].
- out_update_done, out, 1, one-cycle pulse when an armed update completes on all channels.

Function
REQ-003 Word address SHALL be byte address / (AXI4L_DATA_BITS/8); map: 0x00 CORE_ID ro, 0x01 CORE_VERSION ro, 0x03 CONFIG ro (=CHANNELS), 0x04 CTL_CONTROL rw, 0x05 CTL_STATUS ro (out_enable), 0x07 CTL_INDEX ro (8-bit), 0x20+n PARAM_PHASE[n] rw [1:0], 0x30+n PARAM_FLIP[n] rw [1:0], 0x40+n CURRENT_PHASE[n] ro.
REQ-004 CTL_CONTROL bits SHALL be: [0] enable, [1] update (arm), [2] auto (commit every frame).
REQ-005 Writes SHALL honour wstrb per byte; unmapped writes and n>=CHANNELS SHALL be ignored with bresp OKAY; unmapped reads SHALL return 0.
REQ-006 awready and wready SHALL each be (~bvalid|bready) AND the other channel's valid; write occurs when both handshake; bvalid rises next cycle; bresp=0.
REQ-007 arready SHALL be ~rvalid|rready; rdata/rvalid registered, latency 1; rresp=0.
REQ-008 Writing CTL_CONTROL with bit1=1 SHALL set arm[n] for all n; in_update_req SHALL set req[n] for all n.
REQ-009 On in_frame_start[n], channel n SHALL commit if auto=1 or (arm[n]&req[n]); commit loads enable, and phase = PARAM_PHASE[n] XOR PARAM_FLIP[n], visible next cycle; arm[n], req[n] cleared.
REQ-010 CTL_CONTROL bit1 SHALL read as OR of arm[]; when last arm bit clears, CTL_INDEX SHALL increment (wrap 255->0) and out_update_done pulse once, one cycle later.
REQ-011 Auto-mode commits SHALL NOT change CTL_INDEX nor pulse out_update_done unless they clear an arm bit.
REQ-012 Simultaneous register write and commit SHALL commit pre-write values; arm-set by write SHALL win over commit-clear of the same cycle.
REQ-013 in_update_req coincident with in_frame_start[n] SHALL NOT commit that frame; req[n] stays set for the next frame.
REQ-014 Commits on different channels SHALL be independent; channels without frame starts keep their values.

Reset
REQ-015 While s_axi4l_aresetn=0: registers = INIT values, arm=req=0, CTL_INDEX=0, out_enable=0, out_phase = INIT_PARAM_PHASE^INIT_PARAM_FLIP per channel, bvalid=rvalid=0, rdata=0, out_update_done=0.
REQ-016 Reset asserted mid-transaction SHALL drop pending responses; no response after release for pre-reset requests.

Verification
REQ-017 Read 0x00,0x03 -> rdata 0x527a2111, 4; read 0x55 -> 0.
REQ-018 Write PARAM_PHASE[2]=1, FLIP[2]=3, CTL_CONTROL=3, pulse in_update_req, frame_start[2] -> out_phase[5:4]=2, CTL_CONTROL reads 0x3 until channels 0,1,3 start.
REQ-019 After all four frame starts -> CTL_CONTROL=0x1, CTL_INDEX=1, one out_update_done pulse.
REQ-020 CTL_CONTROL=5, PHASE[0]=3, frame_start[0] twice without in_update_req -> out_phase[1:0]=3, CTL_INDEX unchanged.
REQ-021 in_update_req same cycle as frame_start[1] with arm set -> no commit; next frame_start[1] commits.
REQ-022 Assert reset during bvalid=1, bready=0 -> bvalid=0, all outputs at REQ-015 values.
